// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module   : player_motion
// Purpose  : Tick-based jump / duck / gravity motion controller for a sprite.
//            Optional air jump enabled by defining DOUBLE_JUMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module player_motion #(
   parameter int Y_W        = 10,
   parameter int GROUND_Y   = 100,
   parameter int MAX_Y      = 400,
   parameter int JUMP_VEL   = 8,
   parameter int GRAVITY    = 1,
   parameter int TICK_DIV   = 500000,
   parameter int STAND_H    = 20,
   parameter int DUCK_H     = 10,
   parameter int DUCK_TICKS = 30
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           enable,
   input  logic           jump,
   input  logic           duck,
   output logic [Y_W-1:0] player_y,
   output logic [Y_W-1:0] player_h,
   output logic           airborne,
   output logic [1:0]     state,
   output logic           landed
);

   localparam int CNT_W  = $clog2(TICK_DIV);
   localparam int DUCK_W = (DUCK_TICKS > 2) ? $clog2(DUCK_TICKS) : 1;

   localparam logic [CNT_W-1:0]      c_tick_last  = CNT_W'(TICK_DIV - 1);
   localparam logic [DUCK_W-1:0]     c_duck_load  = DUCK_W'(DUCK_TICKS - 1);
   localparam logic [Y_W-1:0]        c_ground_y   = Y_W'(GROUND_Y);
   localparam logic [Y_W-1:0]        c_max_y      = Y_W'(MAX_Y);
   localparam logic [Y_W-1:0]        c_launch_y   = Y_W'(GROUND_Y + JUMP_VEL);
   localparam logic [Y_W-1:0]        c_stand_h    = Y_W'(STAND_H);
   localparam logic [Y_W-1:0]        c_duck_h     = Y_W'(DUCK_H);
   localparam logic signed [Y_W+1:0] c_ground_s   = (Y_W+2)'(GROUND_Y);
   localparam logic signed [Y_W+1:0] c_max_s      = (Y_W+2)'(MAX_Y);
   localparam logic signed [Y_W:0]   c_jump_vel   = (Y_W+1)'(JUMP_VEL);
   localparam logic signed [Y_W:0]   c_gravity    = (Y_W+1)'(GRAVITY);
   localparam logic signed [Y_W:0]   c_launch_vel = (Y_W+1)'(JUMP_VEL - GRAVITY);

   typedef enum logic [1:0] {
      S_GROUND  = 2'd0,
      S_RISING  = 2'd1,
      S_FALLING = 2'd2,
      S_DUCK    = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [Y_W-1:0]        r_y, w_y_nxt;
   logic signed [Y_W:0]   r_vel, w_vel_nxt, w_step_vel, w_vel_dec;
   logic signed [Y_W+1:0] w_pos;
   logic [CNT_W-1:0]      r_tick_cnt;
   logic [DUCK_W-1:0]     r_duck_cnt, w_duck_nxt;
   logic                  r_jump_q, r_jump_pend, r_landed, w_landed_nxt;
   logic                  w_tick, w_jump_edge, w_pend, w_air, w_step_up, w_dec_up;
`ifdef DOUBLE_JUMP_EN
   logic                  r_air_jump, w_dj_fire;
`endif

   assign w_tick      = enable && (r_tick_cnt == c_tick_last);
   assign w_jump_edge = jump && !r_jump_q;
   // An edge arriving on the tick cycle itself is honoured on that tick.
   assign w_pend      = r_jump_pend || w_jump_edge;
   assign w_air       = (r_state == S_RISING) || (r_state == S_FALLING);

   always_comb begin
      w_state_nxt  = r_state;
      w_y_nxt      = r_y;
      w_vel_nxt    = r_vel;
      w_duck_nxt   = r_duck_cnt;
      w_landed_nxt = 1'b0;
      w_step_vel   = r_vel;
`ifdef DOUBLE_JUMP_EN
      w_dj_fire    = w_pend && !r_air_jump;
      if (w_dj_fire) w_step_vel = c_jump_vel;
`endif
      w_pos     = $signed({2'b00, r_y}) + $signed({w_step_vel[Y_W], w_step_vel});
      w_vel_dec = w_step_vel - c_gravity;
      w_step_up = !w_step_vel[Y_W] && (|w_step_vel);
      w_dec_up  = !w_vel_dec[Y_W] && (|w_vel_dec);

      if (w_tick) begin
         case (r_state)
            S_GROUND: begin
               if (w_pend) begin
                  w_y_nxt     = c_launch_y;
                  w_vel_nxt   = c_launch_vel;
                  w_state_nxt = S_RISING;
               end else if (duck) begin
                  w_state_nxt = S_DUCK;
                  w_duck_nxt  = c_duck_load;
               end
            end
            S_RISING, S_FALLING: begin
               if (w_pos <= c_ground_s) begin
                  w_y_nxt      = c_ground_y;
                  w_vel_nxt    = '0;
                  w_state_nxt  = S_GROUND;
                  w_landed_nxt = 1'b1;
               // Clamp only while still moving up, so a player parked at the
               // ceiling with zero velocity is free to start descending.
               end else if ((w_pos >= c_max_s) && w_step_up) begin
                  w_y_nxt     = c_max_y;
                  w_vel_nxt   = '0;
                  w_state_nxt = S_FALLING;
               end else begin
                  w_y_nxt     = w_pos[Y_W-1:0];
                  w_vel_nxt   = w_vel_dec;
                  w_state_nxt = w_dec_up ? S_RISING : S_FALLING;
`ifdef DOUBLE_JUMP_EN
                  if (w_dj_fire) begin
                     w_vel_nxt   = c_jump_vel;
                     w_state_nxt = S_RISING;
                  end
`endif
               end
            end
            S_DUCK: begin
               if (r_duck_cnt == '0) w_state_nxt = S_GROUND;
               else                  w_duck_nxt  = r_duck_cnt - DUCK_W'(1);
            end
            default: w_state_nxt = S_GROUND;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_GROUND;
         r_y         <= c_ground_y;
         r_vel       <= '0;
         r_tick_cnt  <= '0;
         r_duck_cnt  <= '0;
         r_jump_q    <= 1'b0;
         r_jump_pend <= 1'b0;
         r_landed    <= 1'b0;
`ifdef DOUBLE_JUMP_EN
         r_air_jump  <= 1'b0;
`endif
      end else begin
         r_landed <= w_landed_nxt;
         if (enable) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
            r_jump_q   <= jump;
            if (w_tick || (r_state == S_DUCK)) r_jump_pend <= 1'b0;
            else if (w_jump_edge)              r_jump_pend <= 1'b1;
            r_state    <= w_state_nxt;
            r_y        <= w_y_nxt;
            r_vel      <= w_vel_nxt;
            r_duck_cnt <= w_duck_nxt;
`ifdef DOUBLE_JUMP_EN
            if (w_landed_nxt)                    r_air_jump <= 1'b0;
            else if (w_tick && w_air && w_dj_fire) r_air_jump <= 1'b1;
`endif
         end
      end
   end

   assign player_y = r_y;
   assign player_h = (r_state == S_DUCK) ? c_duck_h : c_stand_h;
   assign airborne = w_air;
   assign state    = r_state;
   assign landed   = r_landed;

endmodule
`default_nettype wire
